// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator request issuer.
package elevator_pkg;

   localparam int FLOOR_W    = 3;
   localparam int NUM_FLOORS = 6;

   typedef struct packed {
      logic [FLOOR_W-1:0] src;
      logic [FLOOR_W-1:0] dest;
      logic               dir;
   } req_t;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

endpackage

// File: rtl/elevator_request_issuer_fifo.sv
// Circular-buffer request FIFO. Every slot and its occupancy are exposed so the
// issuer can compare an incoming request against the whole queue in parallel.
module request_fifo
   import elevator_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  req_t                   din_i,
   input  logic                   pop_i,
   output req_t                   dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o,
   output req_t [DEPTH-1:0]       ents_o,
   output logic [DEPTH-1:0]       occ_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_q, rd_q, off;
   logic [AW:0]      cnt_q;
   req_t [DEPTH-1:0] mem_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign ents_o  = mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: occupancy is derived from the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   always_comb begin
      off   = '0;
      occ_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off      = AW'(i) - rd_q;
         occ_o[i] = ({1'b0, off} < cnt_q);
      end
   end

endmodule

// File: rtl/elevator_request_issuer.sv
// Buffers rider requests and issues them one at a time to the elevator controller
// with setup/strobe/hold/gap timing. Optional macro DUP_FILTER_EN drops queued duplicates.
module elevator_request_issuer
   import elevator_pkg::*;
#(
   parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
   parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
   parameter int DEPTH        = 4,
   parameter int PULSE_CYCLES = 1,
   parameter int GAP_CYCLES   = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   input  logic [FLOOR_W-1:0]     req_src,
   input  logic [FLOOR_W-1:0]     req_dest,
   output logic                   req_ready,
   output logic                   req_err,
   input  logic                   ctrl_busy,
   output logic                   set_clk,
   output logic [FLOOR_W-1:0]     src_input,
   output logic [FLOOR_W-1:0]     dest_input,
   output logic                   direction_input,
   output logic [$clog2(DEPTH):0] fifo_count,
`ifdef DUP_FILTER_EN
   output logic                   dup_drop,
`endif
   output logic                   issuing
);

`ifdef DUP_FILTER_EN
   localparam bit DUP_EN = 1'b1;
`else
   localparam bit DUP_EN = 1'b0;
`endif

   logic             accept, bad_req, dup_hit, push, pop, full, empty;
   req_t             wr_ent, head, out_q, out_d;
   req_t [DEPTH-1:0] ents;
   logic [DEPTH-1:0] occ;
   state_t           state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             set_clk_q, req_err_q;

   assign req_ready = !full;
   assign accept    = req_valid && req_ready;
   assign bad_req   = (req_src == req_dest) || (32'(req_src) >= NUM_FLOORS)
                   || (32'(req_dest) >= NUM_FLOORS);
   assign push      = accept && !bad_req && !(DUP_EN && dup_hit);

   always_comb begin
      wr_ent.src  = req_src;
      wr_ent.dest = req_dest;
      wr_ent.dir  = (req_dest > req_src);
   end

   always_comb begin
      dup_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (occ[i] && ents[i].src == req_src && ents[i].dest == req_dest) dup_hit = 1'b1;
   end

   request_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (wr_ent),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count),
      .ents_o  (ents),
      .occ_o   (occ)
   );

   // Busy is only honoured in IDLE; once popped, a request always runs to completion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (!empty && !ctrl_busy) begin
            pop     = 1'b1;
            out_d   = head;
            state_d = SETUP;
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = 16'(PULSE_CYCLES - 1);
         end
         STROBE: if (cnt_q == '0) state_d = HOLD;
                 else cnt_d = cnt_q - 16'd1;
         HOLD: begin
            state_d = GAP;
            cnt_d   = 16'(GAP_CYCLES);
         end
         GAP: if (cnt_q == '0) state_d = IDLE;
              else cnt_d = cnt_q - 16'd1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         out_q     <= '0;
         set_clk_q <= 1'b0;
         req_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         set_clk_q <= (state_d == STROBE);
         req_err_q <= accept && bad_req;
      end
   end

`ifdef DUP_FILTER_EN
   logic dup_drop_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dup_drop_q <= 1'b0;
      else        dup_drop_q <= accept && !bad_req && dup_hit;
   end
   assign dup_drop = dup_drop_q;
`endif

   assign set_clk         = set_clk_q;
   assign req_err         = req_err_q;
   assign src_input       = out_q.src;
   assign dest_input      = out_q.dest;
   assign direction_input = out_q.dir;
   assign issuing         = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);

endmodule

// File: tb/tb_elevator_request_issuer.sv
// Scoreboard bench for elevator_request_issuer: expected issues are queued at push
// time and compared at every set_clk rising edge.
module tb_elevator_request_issuer;

   localparam int FW    = 3;
   localparam int DEPTH = 4;
   localparam int PULSE = 1;
   localparam int GAP   = 24;

   logic          clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, ctrl_busy = 1'b0;
   logic [FW-1:0] req_src = '0, req_dest = '0;
   logic          req_ready, req_err, set_clk, direction_input, issuing;
   logic [FW-1:0] src_input, dest_input;
   logic [2:0]    fifo_count;
`ifdef DUP_FILTER_EN
   logic          dup_drop;
`endif

   elevator_request_issuer #(
      .FLOOR_W(FW), .NUM_FLOORS(6), .DEPTH(DEPTH), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_src(req_src),
      .req_dest(req_dest), .req_ready(req_ready), .req_err(req_err),
      .ctrl_busy(ctrl_busy), .set_clk(set_clk), .src_input(src_input),
      .dest_input(dest_input), .direction_input(direction_input),
      .fifo_count(fifo_count),
`ifdef DUP_FILTER_EN
      .dup_drop(dup_drop),
`endif
      .issuing(issuing)
   );

   always #5 clk = ~clk;

   int              total = 0, bad = 0, cyc = 0, last_rise = 0;
   logic [2*FW:0]   exp_q[$];
   int              rise_log[$];
   logic            prev_set = 1'b0;
   logic [2*FW:0]   last_f = '0;

   always @(posedge clk) cyc++;

   // Issue monitor: fields at each strobe rise vs scoreboard, pulse width and hold at fall.
   always @(negedge clk) begin
      logic [2*FW:0] f, e;
      f = {src_input, dest_input, direction_input};
      if (rst_n) begin
         if (set_clk && !prev_set) begin
            rise_log.push_back(cyc);
            last_rise = cyc;
            last_f    = f;
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL issue_unexpected got=%h", f);
            end else begin
               e = exp_q.pop_front();
               if (f !== e) begin bad++; $display("FAIL issue_fields got=%h want=%h", f, e); end
            end
         end
         if (!set_clk && prev_set) begin
            total++;
            if (cyc - last_rise != PULSE || f !== last_f) begin
               bad++;
               $display("FAIL strobe_hold width=%0d want=%0d fields=%h want=%h",
                        cyc - last_rise, PULSE, f, last_f);
            end
         end
      end
      prev_set = set_clk;
   end

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic push(input logic [FW-1:0] s, input logic [FW-1:0] d,
                       input bit exp_issue, output int acc);
      logic r;
      req_valid = 1'b1; req_src = s; req_dest = d;
      if (exp_issue) exp_q.push_back({s, d, d > s});
      acc = -1;
      for (int k = 0; k < 200; k++) begin
         r = req_ready;
         step();
         if (r) begin acc = cyc; break; end
      end
      req_valid = 1'b0;
      if (acc < 0) begin total++; bad++; $display("FAIL push_timeout src=%0d dest=%0d", s, d); end
   endtask

   task automatic wait_rises(input int n, input int budget);
      int k = 0;
      while (rise_log.size() < n && k < budget) begin step(); k++; end
      total++;
      if (rise_log.size() < n) begin
         bad++; $display("FAIL wait_issue got=%0d want=%0d", rise_log.size(), n);
      end
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((exp_q.size() != 0 || issuing) && k < 600) begin step(); k++; end
      total++;
      if (exp_q.size() != 0 || issuing !== 1'b0) begin
         bad++; $display("FAIL drain pending=%0d issuing=%b want 0/0", exp_q.size(), issuing);
      end
      repeat (GAP + 4) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; #3;
      total++;
      if (set_clk !== 1'b0 || issuing !== 1'b0 || req_err !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl set_clk=%b issuing=%b req_err=%b want 0", set_clk, issuing, req_err);
      end
      total++;
      if ({src_input, dest_input, direction_input} !== '0) begin
         bad++; $display("FAIL reset_fields got=%h want 0", {src_input, dest_input, direction_input});
      end
      total++;
      if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want 0", fifo_count); end
      step(); step();
      rst_n = 1'b1;
      step();
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want 1", req_ready); end
   endtask

   task automatic test_single();
      int acc, n0;
      n0 = rise_log.size();
      push(3'd2, 3'd5, 1'b1, acc);
      total++;
      if (req_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want 0", req_err); end
      total++;
      if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count_up got=%0d want 1", fifo_count); end
      step();
      total++;
      if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_count_pop got=%0d want 0", fifo_count); end
      wait_rises(n0 + 1, 20);
      if (rise_log.size() > n0) begin
         total++;
         if (rise_log[n0] - acc != 2) begin
            bad++; $display("FAIL single_latency got=%0d want 2", rise_log[n0] - acc);
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc, n0;
      n0 = rise_log.size();
      push(3'd3, 3'd4, 1'b1, acc);
      push(3'd4, 3'd3, 1'b1, acc);
      wait_rises(n0 + 2, 100);
      if (rise_log.size() > n0 + 1) begin
         total++;
         if (rise_log[n0 + 1] - rise_log[n0] != 29) begin
            bad++; $display("FAIL b2b_spacing got=%0d want 29", rise_log[n0 + 1] - rise_log[n0]);
         end
      end
   endtask

   task automatic test_invalid();
      int acc, n0;
      n0 = rise_log.size();
      push(3'd3, 3'd3, 1'b0, acc);
      total++;
      if (req_err !== 1'b1 || fifo_count !== 3'd0) begin
         bad++; $display("FAIL inv_same err=%b cnt=%0d want 1/0", req_err, fifo_count);
      end
      step();
      total++;
      if (req_err !== 1'b0) begin bad++; $display("FAIL inv_same_pulse got=%b want 0", req_err); end
      push(3'd6, 3'd1, 1'b0, acc);
      total++;
      if (req_err !== 1'b1 || fifo_count !== 3'd0) begin
         bad++; $display("FAIL inv_range err=%b cnt=%0d want 1/0", req_err, fifo_count);
      end
      step();
      total++;
      if (req_err !== 1'b0) begin bad++; $display("FAIL inv_range_pulse got=%b want 0", req_err); end
      repeat (10) step();
      total++;
      if (rise_log.size() != n0 || fifo_count !== 3'd0) begin
         bad++; $display("FAIL inv_no_issue rises=%0d cnt=%0d want %0d/0", rise_log.size(), fifo_count, n0);
      end
   endtask

   task automatic test_busy_full();
      int acc, n0;
      n0 = rise_log.size();
      ctrl_busy = 1'b1;
      push(3'd1, 3'd2, 1'b1, acc);
      push(3'd2, 3'd3, 1'b1, acc);
      push(3'd3, 3'd4, 1'b1, acc);
      push(3'd4, 3'd5, 1'b1, acc);
      total++;
      if (fifo_count !== 3'd4 || req_ready !== 1'b0) begin
         bad++; $display("FAIL full_state cnt=%0d ready=%b want 4/0", fifo_count, req_ready);
      end
      req_valid = 1'b1; req_src = 3'd5; req_dest = 3'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (req_ready !== 1'b0 || fifo_count !== 3'd4 || set_clk !== 1'b0) begin
            bad++; $display("FAIL full_wait ready=%b cnt=%0d set_clk=%b want 0/4/0", req_ready, fifo_count, set_clk);
         end
      end
      ctrl_busy = 1'b0;
      push(3'd5, 3'd0, 1'b1, acc);
      wait_rises(n0 + 2, 100);
      ctrl_busy = 1'b1;
      total++;
      if (set_clk !== 1'b1) begin bad++; $display("FAIL busy_in_strobe set_clk=%b want 1", set_clk); end
      repeat (4) step();
      ctrl_busy = 1'b0;
      wait_rises(n0 + 5, 300);
      wait_drain();
   endtask

   task automatic test_reset_mid();
      int acc, n0;
      n0 = rise_log.size();
      push(3'd0, 3'd5, 1'b1, acc);
      push(3'd5, 3'd1, 1'b1, acc);
      wait_rises(n0 + 1, 20);
      total++;
      if (set_clk !== 1'b1 || fifo_count !== 3'd1) begin
         bad++; $display("FAIL rstmid_pre set_clk=%b cnt=%0d want 1/1", set_clk, fifo_count);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (set_clk !== 1'b0 || fifo_count !== 3'd0 || issuing !== 1'b0) begin
         bad++; $display("FAIL rstmid_async set_clk=%b cnt=%0d issuing=%b want 0/0/0", set_clk, fifo_count, issuing);
      end
      exp_q.delete();
      step(); step();
      rst_n = 1'b1;
      repeat (40) step();
      total++;
      if (rise_log.size() != n0 + 1) begin
         bad++; $display("FAIL rstmid_stale rises=%0d want %0d", rise_log.size(), n0 + 1);
      end
   endtask

`ifdef DUP_FILTER_EN
   task automatic test_dup();
      int acc, n0;
      n0 = rise_log.size();
      ctrl_busy = 1'b1;
      push(3'd1, 3'd4, 1'b1, acc);
      total++;
      if (dup_drop !== 1'b0 || fifo_count !== 3'd1) begin
         bad++; $display("FAIL dup_first drop=%b cnt=%0d want 0/1", dup_drop, fifo_count);
      end
      push(3'd1, 3'd4, 1'b0, acc);
      total++;
      if (dup_drop !== 1'b1 || fifo_count !== 3'd1 || req_err !== 1'b0) begin
         bad++; $display("FAIL dup_second drop=%b cnt=%0d err=%b want 1/1/0", dup_drop, fifo_count, req_err);
      end
      step();
      total++;
      if (dup_drop !== 1'b0) begin bad++; $display("FAIL dup_pulse got=%b want 0", dup_drop); end
      ctrl_busy = 1'b0;
      wait_rises(n0 + 1, 20);
      wait_drain();
      push(3'd1, 3'd4, 1'b1, acc);
      total++;
      if (dup_drop !== 1'b0 || fifo_count !== 3'd1) begin
         bad++; $display("FAIL dup_after_issue drop=%b cnt=%0d want 0/1", dup_drop, fifo_count);
      end
      wait_drain();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      wait_drain();
      test_back_to_back();
      wait_drain();
      test_invalid();
      test_busy_full();
      test_reset_mid();
`ifdef DUP_FILTER_EN
      test_dup();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
